// File: rtl/updown_trace_decoder.sv
// ---------------------------------------------------------------------------
// updown_trace_decoder
//
// Purpose:
//    Observer-side decoder for an up/down counter. It samples the counter
//    value every clock and recovers the instruction that produced each step:
//    UP, DOWN, RESET or GLITCH (an illegal jump). The decoded stream is
//    run-length encoded into {kind, len} records. The records are queued in
//    a small FIFO, and a consumer drains them over a valid/ready port.
//
// Optional feature:
//    TRACE_STATS_EN - when defined, total_up/total_down count UP/DOWN decodes
//                     and saturate at all-ones. When undefined, both ports
//                     are tied to zero.
//
// Ports:
//    clock         sole clock, rising edge
//    reset         asynchronous active-high reset, clears all state
//    value_in      observed counter value
//    track_en      decode enable
//    dir           last decoded direction (0 = up, 1 = down)
//    dir_valid     last decoded kind was UP or DOWN
//    rec_valid     FIFO head valid
//    rec_ready     consumer accepts head
//    rec_kind      head kind: 00 UP, 01 DOWN, 10 RESET, 11 GLITCH
//    rec_len       head run length
//    overflow      sticky flag, set when a record was dropped
//    overflow_clr  clears overflow
//    total_up      saturating UP step total
//    total_down    saturating DOWN step total
// ---------------------------------------------------------------------------
module updown_trace_decoder #(
   parameter int WIDTH = 32,
   parameter int RUN_W = 16,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] value_in,
   input  logic             track_en,
   output logic             dir,
   output logic             dir_valid,
   output logic             rec_valid,
   input  logic             rec_ready,
   output logic [1:0]       rec_kind,
   output logic [RUN_W-1:0] rec_len,
   output logic             overflow,
   input  logic             overflow_clr,
   output logic [WIDTH-1:0] total_up,
   output logic [WIDTH-1:0] total_down
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRIME = 2'd1;
   localparam logic [1:0] ST_TRACK = 2'd2;

   localparam logic [1:0] K_UP     = 2'd0;
   localparam logic [1:0] K_DOWN   = 2'd1;
   localparam logic [1:0] K_RESET  = 2'd2;
   localparam logic [1:0] K_GLITCH = 2'd3;

   localparam logic [RUN_W-1:0] RUN_MAX  = '1;
   localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);

   logic [1:0]         r_state;
   logic [WIDTH-1:0]   r_prev;
   logic [1:0]         r_runKind;
   logic [RUN_W-1:0]   r_runLen;
   logic               r_dir;
   logic               r_dirValid;
   logic [RUN_W+1:0]   r_mem [DEPTH];
   logic [AW-1:0]      r_wrPtr;
   logic [AW-1:0]      r_rdPtr;
   logic [AW:0]        r_count;
   logic               r_overflow;

   logic [WIDTH-1:0]   w_delta;
   logic [1:0]         w_kind;
   logic               w_decode;
   logic               w_pushReq;
   logic               w_pop;
   logic               w_full;
   logic               w_pushOk;
   logic               w_drop;
   logic [RUN_W+1:0]   w_head;

   // Step classification. The +/-1 tests come first so that wrapping
   // through zero (all-ones to 0, or 1 to 0) reads as a normal step rather
   // than a counter reset.
   assign w_delta = value_in - r_prev;

   always_comb begin
      w_kind = K_GLITCH;
      if (w_delta == WIDTH'(1)) begin
         w_kind = K_UP;
      end else if (w_delta == '1) begin
         w_kind = K_DOWN;
      end else if (value_in == '0) begin
         w_kind = K_RESET;
      end
   end

   assign w_decode = track_en && (r_state != ST_IDLE);

   // The open run is closed when tracking stops, when the kind changes, or
   // when its length field is already at the maximum. The pushed record is
   // always the open run, so kind and length come straight from the run
   // registers.
   assign w_pushReq = (r_state == ST_TRACK) &&
                      (!track_en || (w_kind != r_runKind) || (r_runLen == RUN_MAX));

   assign w_full   = (r_count == FULL_CNT);
   assign w_pop    = rec_valid && rec_ready;
   assign w_pushOk = w_pushReq && (!w_full || w_pop);
   assign w_drop   = w_pushReq && !w_pushOk;

   // Tracking state machine and run-length accumulator.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_prev    <= '0;
         r_runKind <= K_UP;
         r_runLen  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (track_en) begin
                  r_prev  <= value_in;
                  r_state <= ST_PRIME;
               end
            end
            ST_PRIME: begin
               if (track_en) begin
                  r_prev    <= value_in;
                  r_runKind <= w_kind;
                  r_runLen  <= RUN_W'(1);
                  r_state   <= ST_TRACK;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_TRACK: begin
               if (track_en) begin
                  r_prev <= value_in;
                  if ((w_kind == r_runKind) && (r_runLen != RUN_MAX)) begin
                     r_runLen <= r_runLen + RUN_W'(1);
                  end else begin
                     r_runKind <= w_kind;
                     r_runLen  <= RUN_W'(1);
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Direction tracks every decode. RESET and GLITCH keep the old direction
   // but mark it stale.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_dir      <= 1'b0;
         r_dirValid <= 1'b0;
      end else if (w_decode) begin
         case (w_kind)
            K_UP: begin
               r_dir      <= 1'b0;
               r_dirValid <= 1'b1;
            end
            K_DOWN: begin
               r_dir      <= 1'b1;
               r_dirValid <= 1'b1;
            end
            default: begin
               r_dirValid <= 1'b0;
            end
         endcase
      end
   end

   // Record storage needs no reset. Entries are only read while the
   // occupancy count says they are valid.
   always_ff @(posedge clock) begin
      if (w_pushOk) begin
         r_mem[r_wrPtr] <= {r_runKind, r_runLen};
      end
   end

   // FIFO pointers and occupancy. A pop in the same cycle frees the slot,
   // so a push to a full FIFO is still accepted then.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_pushOk) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         case ({w_pushOk, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overflow. A drop in the same cycle as a clear wins, so that
   // loss is not hidden.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (overflow_clr) begin
         r_overflow <= 1'b0;
      end
   end

   // The head is forced to zero while the FIFO is empty, so the record
   // outputs read 0 after reset and between records.
   assign w_head    = r_mem[r_rdPtr];
   assign rec_valid = (r_count != '0);
   assign rec_kind  = rec_valid ? w_head[RUN_W+1:RUN_W] : 2'b00;
   assign rec_len   = rec_valid ? w_head[RUN_W-1:0] : '0;
   assign overflow  = r_overflow;
   assign dir       = r_dir;
   assign dir_valid = r_dirValid;

`ifdef TRACE_STATS_EN
   logic [WIDTH-1:0] r_totalUp;
   logic [WIDTH-1:0] r_totalDown;

   // Step totals saturate at all-ones. Only reset clears them.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_totalUp   <= '0;
         r_totalDown <= '0;
      end else if (w_decode) begin
         if ((w_kind == K_UP) && (r_totalUp != '1)) begin
            r_totalUp <= r_totalUp + WIDTH'(1);
         end
         if ((w_kind == K_DOWN) && (r_totalDown != '1)) begin
            r_totalDown <= r_totalDown + WIDTH'(1);
         end
      end
   end

   assign total_up   = r_totalUp;
   assign total_down = r_totalDown;
`else
   assign total_up   = '0;
   assign total_down = '0;
`endif

endmodule

// File: tb/tb_updown_trace_decoder.sv
// ---------------------------------------------------------------------------
// tb_updown_trace_decoder
//
// Directed bench for updown_trace_decoder. The design is built with
// RUN_W=4 so that run saturation is reachable in a few cycles. The
// step table holds {track_en, value, expected dir, expected dir_valid}, plus
// a marker for how many queued records to drain and compare afterwards.
// Hand-written sequences cover overflow, run saturation and reset mid-run.
// ---------------------------------------------------------------------------
module tb_updown_trace_decoder;

   localparam int WIDTH = 32;
   localparam int RUN_W = 4;
   localparam int DEPTH = 8;

   localparam logic [1:0] K_UP     = 2'd0;
   localparam logic [1:0] K_DOWN   = 2'd1;
   localparam logic [1:0] K_RESET  = 2'd2;
   localparam logic [1:0] K_GLITCH = 2'd3;

`ifdef TRACE_STATS_EN
   localparam logic [WIDTH-1:0] EXP_UP_TOTAL   = 32'd38;
   localparam logic [WIDTH-1:0] EXP_DOWN_TOTAL = 32'd8;
`else
   localparam logic [WIDTH-1:0] EXP_UP_TOTAL   = 32'd0;
   localparam logic [WIDTH-1:0] EXP_DOWN_TOTAL = 32'd0;
`endif

   logic             clock = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] valueIn;
   logic             trackEn;
   logic             dirOut;
   logic             dirValid;
   logic             recValid;
   logic             recReady;
   logic [1:0]       recKind;
   logic [RUN_W-1:0] recLen;
   logic             overflowOut;
   logic             overflowClr;
   logic [WIDTH-1:0] totalUp;
   logic [WIDTH-1:0] totalDown;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        te;
      logic [31:0] v;
      logic        eDir;
      logic        eDv;
      int          nRec;
      logic        drainIt;
   } stepT;

   typedef struct {
      logic [1:0] k;
      logic [3:0] l;
   } recT;

   stepT steps[$];
   recT  expRecs[$];

   always #5 clock = ~clock;

   updown_trace_decoder #(
      .WIDTH(WIDTH),
      .RUN_W(RUN_W),
      .DEPTH(DEPTH)
   ) dut (
      .clock(clock),
      .reset(reset),
      .value_in(valueIn),
      .track_en(trackEn),
      .dir(dirOut),
      .dir_valid(dirValid),
      .rec_valid(recValid),
      .rec_ready(recReady),
      .rec_kind(recKind),
      .rec_len(recLen),
      .overflow(overflowOut),
      .overflow_clr(overflowClr),
      .total_up(totalUp),
      .total_down(totalDown)
   );

   // One comparison. Every mismatch prints a single line and bumps the count.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one sample at the falling edge. The DUT takes it at the next
   // rising edge, and the outputs are read at the falling edge after that.
   task automatic applyStimulus(input logic te, input logic [31:0] v);
      trackEn = te;
      valueIn = v;
      @(posedge clock);
      @(negedge clock);
   endtask

   // Pop n records from the head, compare each against the expected queue,
   // and then confirm that the FIFO is empty.
   task automatic drainRecords(input int n);
      recT r;
      for (int i = 0; i < n; i++) begin
         r = expRecs.pop_front();
         checkOutput("rec_valid", 64'(recValid), 64'd1);
         checkOutput("rec_kind", 64'(recKind), 64'(r.k));
         checkOutput("rec_len", 64'(recLen), 64'(r.l));
         recReady = 1'b1;
         @(posedge clock);
         @(negedge clock);
         recReady = 1'b0;
      end
      checkOutput("fifo_empty", 64'(recValid), 64'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_dir"}, 64'(dirOut), 64'd0);
      checkOutput({tag, "_dir_valid"}, 64'(dirValid), 64'd0);
      checkOutput({tag, "_rec_valid"}, 64'(recValid), 64'd0);
      checkOutput({tag, "_rec_kind"}, 64'(recKind), 64'd0);
      checkOutput({tag, "_rec_len"}, 64'(recLen), 64'd0);
      checkOutput({tag, "_overflow"}, 64'(overflowOut), 64'd0);
      checkOutput({tag, "_total_up"}, 64'(totalUp), 64'd0);
      checkOutput({tag, "_total_down"}, 64'(totalDown), 64'd0);
   endtask

   initial begin
      // Basic runs: count up, up then down, wrap through zero, reset/glitch
      // jumps, and dropping track_en while still in PRIME.
      steps.push_back('{1'b1, 32'd0, 1'b0, 1'b0, 0, 1'b0});
      steps.push_back('{1'b1, 32'd1, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'd2, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'd3, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'd4, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'd5, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b0, 32'd5, 1'b0, 1'b1, 1, 1'b1});
      expRecs.push_back('{K_UP, 4'd5});

      steps.push_back('{1'b1, 32'd10, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'd11, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'd12, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'd13, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'd12, 1'b1, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'd11, 1'b1, 1'b1, 0, 1'b0});
      steps.push_back('{1'b0, 32'd11, 1'b1, 1'b1, 2, 1'b1});
      expRecs.push_back('{K_UP, 4'd3});
      expRecs.push_back('{K_DOWN, 4'd2});

      steps.push_back('{1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'h0000_0001, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'h0000_0000, 1'b1, 1'b1, 0, 1'b0});
      steps.push_back('{1'b0, 32'h0000_0000, 1'b1, 1'b1, 2, 1'b1});
      expRecs.push_back('{K_UP, 4'd3});
      expRecs.push_back('{K_DOWN, 4'd1});

      steps.push_back('{1'b1, 32'd7, 1'b1, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'd8, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'd0, 1'b0, 1'b0, 0, 1'b0});
      steps.push_back('{1'b1, 32'd1, 1'b0, 1'b1, 0, 1'b0});
      steps.push_back('{1'b1, 32'd9, 1'b0, 1'b0, 0, 1'b0});
      steps.push_back('{1'b0, 32'd9, 1'b0, 1'b0, 4, 1'b1});
      expRecs.push_back('{K_UP, 4'd1});
      expRecs.push_back('{K_RESET, 4'd1});
      expRecs.push_back('{K_UP, 4'd1});
      expRecs.push_back('{K_GLITCH, 4'd1});

      steps.push_back('{1'b1, 32'd50, 1'b0, 1'b0, 0, 1'b0});
      steps.push_back('{1'b0, 32'd50, 1'b0, 1'b0, 0, 1'b1});

      reset       = 1'b1;
      trackEn     = 1'b0;
      valueIn     = '0;
      recReady    = 1'b0;
      overflowClr = 1'b0;
      repeat (2) @(negedge clock);
      checkAllZero("in_reset");
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < steps.size(); i++) begin
         applyStimulus(steps[i].te, steps[i].v);
         checkOutput($sformatf("dir_step%0d", i), 64'(dirOut), 64'(steps[i].eDir));
         checkOutput($sformatf("dir_valid_step%0d", i), 64'(dirValid), 64'(steps[i].eDv));
         if (steps[i].drainIt) begin
            drainRecords(steps[i].nRec);
         end
      end

      // Overflow: ten alternating decodes with the consumer stalled give ten
      // records. The first eight fit and the last two are dropped.
      applyStimulus(1'b1, 32'd100);
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b1, (i % 2 == 1) ? 32'd101 : 32'd100);
         checkOutput($sformatf("overflow_after_push%0d", i - 1), 64'(overflowOut),
                     64'((i - 1) > DEPTH));
      end
      applyStimulus(1'b0, 32'd100);
      checkOutput("overflow_set", 64'(overflowOut), 64'd1);
      checkOutput("overflow_full_valid", 64'(recValid), 64'd1);
      for (int j = 0; j < DEPTH; j++) begin
         expRecs.push_back('{(j % 2 == 0) ? K_UP : K_DOWN, 4'd1});
      end
      drainRecords(DEPTH);
      checkOutput("overflow_sticky", 64'(overflowOut), 64'd1);
      overflowClr = 1'b1;
      @(posedge clock);
      @(negedge clock);
      overflowClr = 1'b0;
      checkOutput("overflow_cleared", 64'(overflowOut), 64'd0);

      // Run saturation: with a 4-bit length, 20 UP steps split into 15 + 5.
      applyStimulus(1'b1, 32'd0);
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(1'b1, 32'(i));
      end
      applyStimulus(1'b0, 32'd20);
      expRecs.push_back('{K_UP, 4'd15});
      expRecs.push_back('{K_UP, 4'd5});
      drainRecords(2);

      checkOutput("total_up", 64'(totalUp), 64'(EXP_UP_TOTAL));
      checkOutput("total_down", 64'(totalDown), 64'(EXP_DOWN_TOTAL));

      // Reset mid-run while a saturated record is queued and a run is open.
      applyStimulus(1'b1, 32'd0);
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(1'b1, 32'(i));
      end
      checkOutput("pre_reset_rec_valid", 64'(recValid), 64'd1);
      #2 reset = 1'b1;
      #1 checkAllZero("async_reset");
      @(negedge clock);
      reset = 1'b0;

      // Once reset is released the decoder starts again from IDLE. The
      // first sample is captured only, so the result is a single {UP,2}.
      applyStimulus(1'b1, 32'd40);
      checkOutput("post_reset_idle_dir_valid", 64'(dirValid), 64'd0);
      applyStimulus(1'b1, 32'd41);
      applyStimulus(1'b1, 32'd42);
      applyStimulus(1'b0, 32'd42);
      checkOutput("post_reset_dir", 64'(dirOut), 64'd0);
      checkOutput("post_reset_dir_valid", 64'(dirValid), 64'd1);
      expRecs.push_back('{K_UP, 4'd2});
      drainRecords(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
